// File: rtl/bip_run_controller_pkg.sv
// Shared widths, command codes, FSM encoding and frame helpers for the BIP run controller.
package bip_run_controller_pkg;

  localparam int NB_DATA            = 16;
  localparam int LOG2_N_INSMEM_ADDR = 11;
  localparam int NB_CYCLES          = 32;
  localparam int NB_UART            = 8;
  localparam int NB_PC_FIELD        = 16;
  localparam int FRAME_BYTES        = 8;
  localparam int NB_FRAME           = FRAME_BYTES * NB_UART;
  localparam int NB_IDX             = 3;

  localparam logic [NB_UART-1:0] CMD_RUN  = 8'h52;
  localparam logic [NB_UART-1:0] CMD_STEP = 8'h53;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_STEP    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // Byte 0 is the most significant byte of the frame.
  function automatic logic [NB_UART-1:0] frame_byte(input logic [NB_FRAME-1:0] frame,
                                                     input logic [NB_IDX-1:0]   idx);
    return frame[(FRAME_BYTES - 1 - int'(idx)) * NB_UART +: NB_UART];
  endfunction

endpackage

// File: rtl/bip_run_controller_if.sv
// Host UART link between the run controller (master) and the rx/tx pair (slave).
interface bip_run_controller_if;
  import bip_run_controller_pkg::*;

  logic [NB_UART-1:0] rx_data;
  logic               rx_valid;
  logic               tx_done;
  logic [NB_UART-1:0] tx_data;
  logic               tx_start;

  modport master (input rx_data, rx_valid, tx_done, output tx_data, tx_start);
  modport slave  (output rx_data, rx_valid, tx_done, input tx_data, tx_start);

endinterface

// File: rtl/bip_run_controller_tx_serializer.sv
// Snapshots the 8-byte result frame and presents one byte per transmit request.
module bip_run_controller_tx_serializer
  import bip_run_controller_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_send,
  input  logic                i_advance,
  input  logic [NB_FRAME-1:0] i_frame,
  output logic [NB_UART-1:0]  o_tx_data,
  output logic                o_tx_start,
  output logic                o_last
);

  logic [NB_FRAME-1:0] r_frame;
  logic [NB_IDX-1:0]   r_index;
  logic [NB_UART-1:0]  r_tx_data;
  logic                r_tx_start;
  logic [NB_FRAME-1:0] w_frame;
  logic                w_last;

  // First byte reads the live frame so the snapshot reflects a just-completed step.
  assign w_frame = (r_index == '0) ? i_frame : r_frame;
  assign w_last  = (r_index == NB_IDX'(FRAME_BYTES - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_frame    <= '0;
      r_index    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      if (i_send) begin
        if (r_index == '0) r_frame <= i_frame;
        r_tx_data  <= frame_byte(w_frame, r_index);
        r_tx_start <= 1'b1;
      end
      if (i_advance) r_index <= w_last ? '0 : r_index + NB_IDX'(1);
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_last     = w_last;

endmodule

// File: rtl/bip_run_controller.sv
// Host-driven run/step sequencer for the BIP core: reset/enable control, cycle count, result frame.
module bip_run_controller
  import bip_run_controller_pkg::*;
(
  input  logic                          i_clock,
  input  logic                          i_reset,
  bip_run_controller_if.master          io_uart,
  input  logic                          i_halt,
  input  logic [NB_DATA-1:0]            i_acc,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
  output logic                          o_cpu_valid,
  output logic                          o_cpu_reset,
  output logic                          o_busy
);

  state_t               r_state;
  state_t               w_next;
  logic [NB_CYCLES-1:0] r_cycles;
  logic                 r_cpu_valid;
  logic                 r_cpu_reset;
  logic                 r_busy;
  logic                 w_last;
  logic [NB_FRAME-1:0]  w_frame;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_uart.rx_valid) begin
          if (io_uart.rx_data == CMD_RUN)       w_next = ST_CLEAR;
          else if (io_uart.rx_data == CMD_STEP) w_next = ST_STEP;
        end
      end
      ST_CLEAR:   w_next = ST_RUN;
      ST_RUN:     if (i_halt) w_next = ST_SEND;
      ST_STEP:    w_next = ST_SEND;
      ST_SEND:    w_next = ST_WAIT_TX;
      ST_WAIT_TX: if (io_uart.tx_done) w_next = w_last ? ST_IDLE : ST_SEND;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Core controls are decoded from the next state so they stay registered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cpu_valid <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_cpu_valid <= (w_next == ST_RUN) || (w_next == ST_STEP);
      r_cpu_reset <= (w_next == ST_CLEAR);
      r_busy      <= (w_next != ST_IDLE);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || r_state == ST_CLEAR) begin
      r_cycles <= '0;
    end else if (r_cpu_valid && !i_halt && r_cycles != '1) begin
      r_cycles <= r_cycles + NB_CYCLES'(1);
    end
  end

  assign w_frame = {i_acc, {(NB_PC_FIELD - LOG2_N_INSMEM_ADDR){1'b0}}, i_pc, r_cycles};

  bip_run_controller_tx_serializer u_serializer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_send     (r_state == ST_SEND),
    .i_advance  ((r_state == ST_WAIT_TX) && io_uart.tx_done),
    .i_frame    (w_frame),
    .o_tx_data  (io_uart.tx_data),
    .o_tx_start (io_uart.tx_start),
    .o_last     (w_last)
  );

  assign o_cpu_valid = r_cpu_valid;
  assign o_cpu_reset = r_cpu_reset;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_bip_run_controller.sv
// Scoreboard bench for bip_run_controller with a behavioural core and UART transmitter model.
module tb_bip_run_controller;
  import bip_run_controller_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        halt;
  logic        cpu_valid;
  logic        cpu_reset;
  logic        busy;
  logic [15:0] core_acc;
  logic [10:0] core_pc = '0;
  logic [10:0] halt_pc;

  bip_run_controller_if uart_if ();

  bip_run_controller dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .io_uart     (uart_if),
    .i_halt      (halt),
    .i_acc       (core_acc),
    .i_pc        (core_pc),
    .o_cpu_valid (cpu_valid),
    .o_cpu_reset (cpu_reset),
    .o_busy      (busy)
  );

  // Core model: the instruction at halt_pc is HALT; PC advances on every enabled non-HALT cycle.
  assign halt = (core_pc == halt_pc);
  always @(posedge clk) begin
    if (cpu_reset)              core_pc <= '0;
    else if (cpu_valid && !halt) core_pc <= core_pc + 11'd1;
  end

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_valid = 0;
  int n_rpulse = 0;
  int tx_delay = 3;
  logic [7:0]  exp_q[$];
  logic [31:0] m_cycles;
  logic [10:0] m_pc;

  // Transmitter model: raises tx_done tx_delay cycles after each start.
  initial begin
    int cnt;
    cnt = 0;
    uart_if.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      uart_if.tx_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) uart_if.tx_done = 1'b1;
      end
      if (uart_if.tx_start) cnt = tx_delay;
    end
  end

  // Monitor: every transmit request pops one expected byte.
  initial begin
    logic       prev_cr;
    logic [7:0] e;
    prev_cr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (uart_if.tx_start) begin
        n_start++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte: got %02h, expected no transmission", uart_if.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (uart_if.tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte #%0d: got %02h expected %02h", n_start, uart_if.tx_data, e);
          end
        end
      end
      if (cpu_valid) n_valid++;
      if (cpu_reset && !prev_cr && !rst) n_rpulse++;
      prev_cr = cpu_reset;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_if.rx_data  = b;
    uart_if.rx_valid = 1'b1;
    @(negedge clk);
    uart_if.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic push_frame(input logic [15:0] a, input logic [10:0] p, input logic [31:0] c);
    logic [63:0] f;
    f = {a, 16'(p), c};
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(f >> (8 * (7 - i))));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    uart_if.rx_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    m_cycles = '0;
    m_pc = '0;
    tick(2);
  endtask

  // Model of a RUN command: core restarts from 0 and executes up to HALT.
  task automatic model_run();
    m_pc = halt_pc;
    m_cycles = 32'(halt_pc);
    push_frame(core_acc, m_pc, m_cycles);
  endtask

  task automatic model_step();
    if (m_pc != halt_pc) begin
      m_pc = m_pc + 11'd1;
      m_cycles = sat_inc(m_cycles);
    end
    push_frame(core_acc, m_pc, m_cycles);
  endtask

  initial begin
    int b_start, b_valid, b_rp, n;
    rst = 1'b1;
    uart_if.rx_data  = '0;
    uart_if.rx_valid = 1'b0;
    halt_pc  = 11'd5;
    core_acc = 16'h1234;
    m_cycles = '0;
    m_pc     = '0;

    // Reset values and release
    tick(3);
    check("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("rst_cpu_valid", {63'd0, cpu_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_tx_start", {63'd0, uart_if.tx_start}, 64'd0);
    rst = 1'b0;
    tick(1);
    check("cpu_reset_release", {63'd0, cpu_reset}, 64'd0);
    tick(2);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Unknown byte, then RUN to HALT at pc 5
    send_byte(8'h41);
    check("ignored_byte_busy", {63'd0, busy}, 64'd0);
    b_start = n_start; b_valid = n_valid; b_rp = n_rpulse;
    model_run();
    @(negedge clk);
    uart_if.rx_data = CMD_RUN;
    uart_if.rx_valid = 1'b1;
    @(negedge clk);
    uart_if.rx_valid = 1'b0;
    check("clear_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("clear_cpu_valid", {63'd0, cpu_valid}, 64'd0);
    @(negedge clk);
    check("run_cpu_valid", {63'd0, cpu_valid}, 64'd1);
    wait_idle("run1_idle", 300);
    check("run1_valid_cycles", 64'(n_valid - b_valid), 64'd6);
    check("run1_reset_pulses", 64'(n_rpulse - b_rp), 64'd1);
    check("run1_tx_starts", 64'(n_start - b_start), 64'd8);
    check("run1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Two single steps from a fresh reset, then a step on a halted core
    do_reset();
    halt_pc = 11'd100;
    core_acc = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) halt_pc = m_pc;
      b_valid = n_valid; b_rp = n_rpulse; b_start = n_start;
      model_step();
      send_byte(CMD_STEP);
      wait_idle("step_idle", 300);
      check("step_valid_cycles", 64'(n_valid - b_valid), 64'd1);
      check("step_reset_pulses", 64'(n_rpulse - b_rp), 64'd0);
      check("step_tx_starts", 64'(n_start - b_start), 64'd8);
    end

    // Slow transmitter with STEP bytes injected mid-frame
    tx_delay = 20;
    halt_pc = 11'($urandom_range(1, 10));
    core_acc = 16'($urandom);
    b_start = n_start; b_valid = n_valid;
    model_run();
    send_byte(CMD_RUN);
    for (int i = 0; i < 6; i++) begin
      tick($urandom_range(5, 25));
      if (busy) send_byte(CMD_STEP);
    end
    wait_idle("slow_idle", 600);
    check("slow_tx_starts", 64'(n_start - b_start), 64'd8);
    check("slow_valid_cycles", 64'(n_valid - b_valid), 64'(halt_pc) + 64'd1);
    tick(6);
    check("slow_no_restart", {63'd0, busy}, 64'd0);
    check("slow_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random mix of RUN and STEP commands
    for (int it = 0; it < 6; it++) begin
      tx_delay = $urandom_range(1, 6);
      core_acc = 16'($urandom);
      b_start = n_start;
      if ($urandom_range(0, 1) == 1) begin
        halt_pc = 11'($urandom_range(0, 12));
        model_run();
        send_byte(CMD_RUN);
      end else begin
        halt_pc = m_pc + 11'($urandom_range(0, 2));
        model_step();
        send_byte(CMD_STEP);
      end
      wait_idle("rand_idle", 400);
      check("rand_tx_starts", 64'(n_start - b_start), 64'd8);
    end

    // Counter saturation: preload near all-ones, four more counted cycles
    tx_delay = 2;
    halt_pc = 11'd5;
    core_acc = 16'($urandom);
    m_pc = 11'd5;
    m_cycles = 32'hFFFF_FFFF;
    push_frame(core_acc, m_pc, m_cycles);
    send_byte(CMD_RUN);
    n = 0;
    while (!(cpu_valid && core_pc == 11'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    force dut.r_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycles;
    wait_idle("sat_idle", 300);
    check("sat_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset wins over a simultaneous command byte
    @(negedge clk);
    rst = 1'b1;
    uart_if.rx_data = CMD_RUN;
    uart_if.rx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    uart_if.rx_valid = 1'b0;
    tick(2);
    check("rst_vs_rx_busy", {63'd0, busy}, 64'd0);
    m_cycles = '0;
    m_pc = '0;

    // Reset while waiting on the third byte abandons the frame
    tx_delay = 20;
    halt_pc = 11'd3;
    core_acc = 16'($urandom);
    b_start = n_start;
    model_run();
    send_byte(CMD_RUN);
    n = 0;
    while ((n_start - b_start) < 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midframe_rst_busy", {63'd0, busy}, 64'd0);
    check("midframe_rst_tx_start", {63'd0, uart_if.tx_start}, 64'd0);
    exp_q.delete();
    m_cycles = '0;
    m_pc = '0;
    tick(60);
    check("midframe_starts", 64'(n_start - b_start), 64'd3);
    tx_delay = 3;
    halt_pc = 11'd4;
    core_acc = 16'($urandom);
    b_start = n_start;
    model_run();
    send_byte(CMD_RUN);
    wait_idle("post_rst_idle", 300);
    check("post_rst_starts", 64'(n_start - b_start), 64'd8);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
